// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32 constants, fetch FSM state type and opcode helper.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

   function automatic logic is_legal_opcode(input logic [6:0] opcode);
      logic legal;
      case (opcode)
         OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
         OPC_BRANCH, OPC_LUI, OPC_JAL: legal = 1'b1;
         default:                      legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Single-outstanding instruction fetch with IF/ID register,
//            one-entry skid buffer and branch redirect/flush.
// Revision : 1.0
// ============================================================================
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        dec_ready,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        instr_illegal
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_fetch_pc;
   logic            r_drop;

   logic            r_buf_full;
   logic [XLEN-1:0] r_buf_instr;
   logic [XLEN-1:0] r_buf_pc;
   logic            r_buf_illegal;

   logic            r_instr_valid;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_pc;
   logic            r_instr_illegal;

   logic [XLEN-1:0] w_pc_inc;
   logic            w_rdata_illegal;
   logic            w_unused_br_lsb;

   assign w_pc_inc        = r_fetch_pc + 32'd4;
   assign w_rdata_illegal = ~is_legal_opcode(imem_rdata[6:0]);
   assign w_unused_br_lsb = ^br_target[1:0];

   assign imem_req      = (r_state == ISSUE);
   assign imem_addr     = r_fetch_pc;
   assign instr_valid   = r_instr_valid;
   assign instr         = r_instr;
   assign pc            = r_pc;
   assign instr_illegal = r_instr_illegal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= BOOT;
         r_fetch_pc      <= RESET_PC;
         r_drop          <= 1'b0;
         r_buf_full      <= 1'b0;
         r_buf_instr     <= '0;
         r_buf_pc        <= '0;
         r_buf_illegal   <= 1'b0;
         r_instr_valid   <= 1'b0;
         r_instr         <= '0;
         r_pc            <= '0;
         r_instr_illegal <= 1'b0;
      end else begin
         // Consumption frees IF/ID; a load below in the same cycle overrides.
         if (r_instr_valid && dec_ready) begin
            r_instr_valid <= 1'b0;
         end

         if (br_taken && (r_state != BOOT)) begin
            r_fetch_pc    <= {br_target[XLEN-1:2], 2'b00};
            r_instr_valid <= 1'b0;
            r_buf_full    <= 1'b0;
            case (r_state)
               ISSUE: begin
                  r_drop  <= 1'b1;
                  r_state <= WAIT;
               end
               WAIT: begin
                  // A response arriving now is stale; otherwise mark the pending one.
                  if (imem_rvalid) begin
                     r_drop  <= 1'b0;
                     r_state <= ISSUE;
                  end else begin
                     r_drop  <= 1'b1;
                  end
               end
               default: r_state <= ISSUE;
            endcase
         end else begin
            case (r_state)
               BOOT:  r_state <= ISSUE;
               ISSUE: r_state <= WAIT;
               WAIT: begin
                  if (imem_rvalid) begin
                     r_state <= ISSUE;
                     if (r_drop) begin
                        r_drop <= 1'b0;
                     end else begin
                        r_fetch_pc <= w_pc_inc;
                        if (!r_instr_valid || dec_ready) begin
                           r_instr_valid   <= 1'b1;
                           r_instr         <= imem_rdata;
                           r_pc            <= r_fetch_pc;
                           r_instr_illegal <= w_rdata_illegal;
                        end else begin
                           r_buf_full    <= 1'b1;
                           r_buf_instr   <= imem_rdata;
                           r_buf_pc      <= r_fetch_pc;
                           r_buf_illegal <= w_rdata_illegal;
                           r_state       <= HOLD;
                        end
                     end
                  end
               end
               HOLD: begin
                  if (dec_ready && r_buf_full) begin
                     r_instr_valid   <= 1'b1;
                     r_instr         <= r_buf_instr;
                     r_pc            <= r_buf_pc;
                     r_instr_illegal <= r_buf_illegal;
                     r_buf_full      <= 1'b0;
                     r_state         <= ISSUE;
                  end
               end
               default: r_state <= BOOT;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed and randomized bench for fetch_stage with a
//            stream-level reference model and a behavioural memory.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        dec_ready = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_illegal;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .dec_ready     (dec_ready),
      .br_taken      (br_taken),
      .br_target     (br_target),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .pc            (pc),
      .instr_illegal (instr_illegal)
   );

   int total = 0;
   int bad   = 0;

   // Memory image: fixed words at chosen addresses, pseudo-random elsewhere.
   logic [31:0] ovr [logic [31:0]];
   logic        mem_busy = 1'b0;
   int          mem_cnt  = 0;
   int          mem_lat  = 1;
   logic [31:0] mem_addr = '0;

   // Stream model: address the decoder must see next, plus hold/flush tracking.
   logic [31:0] exp_pc = RST_PC;
   logic        br_prev = 1'b0;
   logic        hold_prev = 1'b0;
   logic [31:0] h_instr = '0;
   logic [31:0] h_pc = '0;
   logic        h_ill = 1'b0;
   int          delivered = 0;
   int          cyc = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] x;
      logic [6:0]  ops [8];
      if (ovr.exists(a)) return ovr[a];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h7F};
      x = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
      return {x[31:7], ops[x[4:2]]};
   endfunction

   function automatic logic is_legal(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                        7'b1100011, 7'b0110111, 7'b1101111};
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Close the current cycle: score what decode takes, step to the next
   // cycle, then play the memory side and check flush/hold behaviour.
   task automatic cycle();
      if (instr_valid && dec_ready) begin
         chk32("deliver_pc", pc, exp_pc);
         chk32("deliver_instr", instr, mem_word(pc));
         chk1("deliver_illegal", instr_illegal, !is_legal(instr[6:0]));
         exp_pc = pc + 32'd4;
         delivered++;
      end
      if (br_taken) exp_pc = {br_target[31:2], 2'b00};
      hold_prev = instr_valid && !dec_ready && !br_taken;
      h_instr   = instr;
      h_pc      = pc;
      h_ill     = instr_illegal;
      br_prev   = br_taken;

      @(posedge clk);
      #1;
      cyc++;
      br_taken    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
            mem_busy    = 1'b0;
         end
      end
      if (imem_req) begin
         chk1("one_outstanding", mem_busy | imem_rvalid, 1'b0);
         chk32("req_aligned", {30'b0, imem_addr[1:0]}, 32'd0);
         mem_busy = 1'b1;
         mem_addr = imem_addr;
         mem_cnt  = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 3));
      end
      if (br_prev) chk1("flush_valid", instr_valid, 1'b0);
      if (hold_prev) begin
         chk1("hold_valid", instr_valid, 1'b1);
         chk32("hold_instr", instr, h_instr);
         chk32("hold_pc", pc, h_pc);
         chk1("hold_illegal", instr_illegal, h_ill);
      end
   endtask

   task automatic do_reset(input bit inject);
      reset       = 1'b1;
      br_taken    = 1'b0;
      imem_rvalid = 1'b0;
      #1;
      chk1("rst_valid", instr_valid, 1'b0);
      chk1("rst_req", imem_req, 1'b0);
      chk32("rst_pc", pc, 32'd0);
      chk32("rst_instr", instr, 32'd0);
      chk1("rst_illegal", instr_illegal, 1'b0);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      mem_busy  = 1'b0;
      exp_pc    = RST_PC;
      br_prev   = 1'b0;
      hold_prev = 1'b0;
      cyc       = 0;
      chk1("boot_req", imem_req, 1'b0);
      if (inject) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'h0000_0013;
      end
   endtask

   initial begin
      int d0;
      ovr[32'h100] = 32'h0050_0093;
      ovr[32'h304] = 32'h0000_007F;
      ovr[32'h308] = 32'h0000_006F;

      // Reset release and best-case first fetch
      mem_lat   = 1;
      dec_ready = 1'b1;
      do_reset(1'b0);
      cycle();
      chk1("c1_req", imem_req, 1'b1);
      chk32("c1_addr", imem_addr, 32'h100);
      cycle();
      chk1("c2_valid", instr_valid, 1'b0);
      cycle();
      chk1("c3_valid", instr_valid, 1'b1);
      chk32("c3_pc", pc, 32'h100);
      chk32("c3_instr", instr, 32'h0050_0093);
      chk1("c3_illegal", instr_illegal, 1'b0);
      chk1("c3_req", imem_req, 1'b1);
      chk32("c3_addr", imem_addr, 32'h104);

      // Back-pressure: 104 lands in the skid buffer, no further request
      dec_ready = 1'b0;
      for (int i = 4; i <= 8; i++) begin
         cycle();
         chk32("bp_pc", pc, 32'h100);
         if (i >= 5) chk1("bp_no_req", imem_req, 1'b0);
      end
      dec_ready = 1'b1;
      mem_lat   = 4;
      cycle();
      chk32("bp_release_pc", pc, 32'h104);
      chk1("bp_release_valid", instr_valid, 1'b1);
      chk32("bp_next_addr", imem_addr, 32'h108);

      // Redirect while waiting; the late response must be dropped
      cycle();
      chk1("br_wait_valid", instr_valid, 1'b0);
      br_taken  = 1'b1;
      br_target = 32'h206;
      for (int i = 11; i <= 13; i++) begin
         cycle();
         chk1("br_drop_valid", instr_valid, 1'b0);
         chk1("br_drop_noreq", imem_req, 1'b0);
      end
      mem_lat = 1;
      cycle();
      chk1("br_req", imem_req, 1'b1);
      chk32("br_addr", imem_addr, 32'h204);
      chk1("br_req_valid", instr_valid, 1'b0);
      cycle();
      chk1("br_c15_valid", instr_valid, 1'b0);
      cycle();
      chk1("br_c16_valid", instr_valid, 1'b1);
      chk32("br_c16_pc", pc, 32'h204);

      // Redirect coincident with a response
      cycle();
      chk1("brr_rvalid", imem_rvalid, 1'b1);
      br_taken  = 1'b1;
      br_target = 32'h300;
      cycle();
      chk1("brr_valid", instr_valid, 1'b0);
      chk1("brr_req", imem_req, 1'b1);
      chk32("brr_addr", imem_addr, 32'h300);
      cycle();
      cycle();
      chk32("brr_pc", pc, 32'h300);

      // Illegal / legal opcode flagging
      cycle();
      cycle();
      chk1("ill_valid", instr_valid, 1'b1);
      chk32("ill_instr", instr, 32'h0000_007F);
      chk1("ill_flag", instr_illegal, 1'b1);
      mem_lat = 3;
      cycle();
      cycle();
      chk32("jal_pc", pc, 32'h308);
      chk1("jal_flag", instr_illegal, 1'b0);

      // Reset during WAIT with a stray response in BOOT
      cycle();
      do_reset(1'b1);
      cycle();
      chk1("rr_req", imem_req, 1'b1);
      chk32("rr_addr", imem_addr, RST_PC);
      chk1("rr_valid1", instr_valid, 1'b0);
      for (int i = 2; i <= 4; i++) begin
         cycle();
         chk1("rr_valid", instr_valid, 1'b0);
      end
      cycle();
      chk1("rr_first_valid", instr_valid, 1'b1);
      chk32("rr_first_pc", pc, RST_PC);

      // Randomized traffic against the stream model
      do_reset(1'b0);
      mem_lat = 0;
      d0 = delivered;
      for (int n = 0; n < 3000; n++) begin
         dec_ready = ($urandom_range(0, 9) < 7);
         br_taken  = (cyc >= 1) && ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0)
            br_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else
            br_target = $urandom;
         cycle();
      end
      chk1("liveness", (delivered - d0) >= 100, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
